// File: rtl/until_monitor_if.sv
`timescale 1ns/1ps
// Trace inputs (A..D) and verdict outputs of until_monitor; master = trace source, slave = monitor.
// With UNTIL_MON_STATS_EN defined the bundle also carries the pass/fail counters.
interface until_monitor_if;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic       busy;
  logic       pass;
  logic       fail;
  logic [1:0] fail_cause;
  logic       overlap;
`ifdef UNTIL_MON_STATS_EN
  logic [7:0] pass_count;
  logic [7:0] fail_count;

  modport master (
    output A, B, C, D,
    input  busy, pass, fail, fail_cause, overlap, pass_count, fail_count
  );
  modport slave (
    input  A, B, C, D,
    output busy, pass, fail, fail_cause, overlap, pass_count, fail_count
  );
`else
  modport master (
    output A, B, C, D,
    input  busy, pass, fail, fail_cause, overlap
  );
  modport slave (
    input  A, B, C, D,
    output busy, pass, fail, fail_cause, overlap
  );
`endif
endinterface

// File: rtl/until_monitor.sv
`timescale 1ns/1ps
// Run-time checker for $rose(A) |=> (B ##DELAY C) until[_with] D; verdicts are registered one-cycle pulses.
// Optional macro UNTIL_MON_STATS_EN adds saturating 8-bit pass_count/fail_count outputs.
module until_monitor #(
  parameter int DELAY = 2,  // legal range 1..15
  parameter int WITH  = 0   // 0: until, 1: until_with
) (
  input  logic           clock,
  input  logic           resetn,
  until_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // pend[DELAY-1] is the bit whose C check falls due this cycle
  localparam logic [DELAY-1:0] EXIT_MASK = DELAY'(1) << (DELAY - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DELAY-1:0] r_pend;
  logic [DELAY-1:0] w_pend_nxt;
  logic             r_a_q;
  logic             r_pass;
  logic             r_fail;
  logic [1:0]       r_cause;
  logic             r_overlap;
  logic             w_rise;
  logic             w_exit;
  logic             w_rem;
  logic             w_bfail;
  logic             w_cfail;
  logic             w_fail_nxt;
  logic             w_pass_nxt;
  logic             w_overlap_nxt;

  assign w_rise = bus.A & ~r_a_q;
  assign w_exit = r_pend[DELAY-1];
  assign w_rem  = |(r_pend & ~EXIT_MASK);

  always_comb begin
    w_state_nxt   = r_state;
    w_pend_nxt    = r_pend << 1;
    w_bfail       = 1'b0;
    w_cfail       = (r_state != IDLE) && w_exit && !bus.C;
    w_pass_nxt    = 1'b0;
    w_overlap_nxt = w_rise && (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (w_rise) w_state_nxt = ARMED;
      end
      ARMED: begin
        if (WITH == 0 && bus.D) begin
          w_state_nxt = DRAIN;
        end else begin
          w_bfail    = !bus.B;
          w_pend_nxt = (r_pend << 1) | DELAY'(1'b1);
          if (bus.D) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!w_rem) begin
          w_state_nxt = IDLE;
          w_pass_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // A violation overrides release and completion decided above
    w_fail_nxt = w_bfail | w_cfail;
    if (w_fail_nxt) begin
      w_state_nxt = IDLE;
      w_pend_nxt  = '0;
      w_pass_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_pend    <= '0;
      r_a_q     <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_cause   <= 2'b00;
      r_overlap <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pend    <= w_pend_nxt;
      r_a_q     <= bus.A;
      r_pass    <= w_pass_nxt;
      r_fail    <= w_fail_nxt;
      r_cause   <= w_fail_nxt ? {w_cfail, w_bfail} : 2'b00;
      r_overlap <= w_overlap_nxt;
    end
  end

  assign bus.busy       = (r_state != IDLE);
  assign bus.pass       = r_pass;
  assign bus.fail       = r_fail;
  assign bus.fail_cause = r_cause;
  assign bus.overlap    = r_overlap;

`ifdef UNTIL_MON_STATS_EN
  logic [7:0] r_pass_cnt;
  logic [7:0] r_fail_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pass_cnt <= 8'd0;
      r_fail_cnt <= 8'd0;
    end else begin
      if (w_pass_nxt && r_pass_cnt != 8'hFF) r_pass_cnt <= r_pass_cnt + 8'd1;
      if (w_fail_nxt && r_fail_cnt != 8'hFF) r_fail_cnt <= r_fail_cnt + 8'd1;
    end
  end

  assign bus.pass_count = r_pass_cnt;
  assign bus.fail_count = r_fail_cnt;
`endif

endmodule

// File: tb/tb_until_monitor.sv
`timescale 1ns/1ps
// Bench for until_monitor: four configurations share one trace and are checked every cycle
// against a due-time queue model, plus literal expectations for the directed scenarios.
module tb_until_monitor;
  localparam int NI = 4;
  // instance g: DELAY = DLYS[4g+:4], WITH = WTHS[g]  -> (2,0) (2,1) (1,0) (15,1)
  localparam logic [15:0] DLYS = {4'd15, 4'd1, 4'd2, 4'd2};
  localparam logic [3:0]  WTHS = 4'b1010;

  logic clock = 1'b0;
  logic resetn = 1'b1;
  logic t_a = 1'b0, t_b = 1'b0, t_c = 1'b0, t_d = 1'b0;
  logic [NI-1:0] o_busy, o_pass, o_fail, o_ovl;
  logic [1:0]    o_cause [NI];
`ifdef UNTIL_MON_STATS_EN
  logic [7:0]    o_pcnt [NI];
  logic [7:0]    o_fcnt [NI];
`endif

  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    until_monitor_if bus();
    assign bus.A = t_a;
    assign bus.B = t_b;
    assign bus.C = t_c;
    assign bus.D = t_d;
    assign o_busy[g]  = bus.busy;
    assign o_pass[g]  = bus.pass;
    assign o_fail[g]  = bus.fail;
    assign o_cause[g] = bus.fail_cause;
    assign o_ovl[g]   = bus.overlap;
`ifdef UNTIL_MON_STATS_EN
    assign o_pcnt[g]  = bus.pass_count;
    assign o_fcnt[g]  = bus.fail_count;
`endif
    until_monitor #(.DELAY(int'(DLYS[g*4 +: 4])), .WITH(int'(WTHS[g]))) u_dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
    );
  end

  int n_cmp = 0;
  int n_err = 0;
  int t;

  // model: an attempt is a flag plus a FIFO of cycles at which C must be 1
  bit   m_aq  [NI];
  bit   m_act [NI];
  bit   m_drn [NI];
  int   m_due [NI][32];
  int   m_hd  [NI];
  int   m_tl  [NI];
  int   m_pc  [NI];
  int   m_fc  [NI];

  int         ev_pass  [NI];
  int         ev_fail  [NI];
  int         ev_ovl   [NI];
  logic [1:0] ev_cause [NI];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_aq[i] = 0; m_act[i] = 0; m_drn[i] = 0;
      m_hd[i] = 0; m_tl[i] = 0; m_pc[i] = 0; m_fc[i] = 0;
    end
  endtask

  task automatic ev_clear();
    for (int i = 0; i < NI; i++) begin
      ev_pass[i] = -1; ev_fail[i] = -1; ev_ovl[i] = -1; ev_cause[i] = 2'b00;
    end
  endtask

  // returns {busy, pass, fail, cause[1:0], overlap} expected after the edge of cycle t
  task automatic model_step(input int i, input bit a, b, c, d, output logic [5:0] e);
    int  n = int'(DLYS[i*4 +: 4]);
    bit  w = WTHS[i];
    bit  rise = a && !m_aq[i];
    bit  ep = 0, ef = 0, eo = 0, bf = 0, cf = 0, rel = 0;
    m_aq[i] = a;
    if (m_act[i]) begin
      eo = rise;
      if (m_hd[i] != m_tl[i] && m_due[i][m_hd[i]] == t) begin
        cf = !c;
        m_hd[i] = (m_hd[i] + 1) % 32;
      end
      if (!m_drn[i]) begin
        rel = d;
        if (!(d && !w)) begin
          bf = !b;
          m_due[i][m_tl[i]] = t + n;
          m_tl[i] = (m_tl[i] + 1) % 32;
        end
      end
      if (bf || cf) begin
        ef = 1; m_act[i] = 0; m_drn[i] = 0; m_hd[i] = 0; m_tl[i] = 0;
      end else if (m_drn[i]) begin
        if (m_hd[i] == m_tl[i]) begin
          ep = 1; m_act[i] = 0; m_drn[i] = 0;
        end
      end else if (rel) begin
        m_drn[i] = 1;
      end
    end else if (rise) begin
      m_act[i] = 1; m_drn[i] = 0;
    end
    if (ep && m_pc[i] < 255) m_pc[i]++;
    if (ef && m_fc[i] < 255) m_fc[i]++;
    e = {m_act[i], ep, ef, (ef ? {cf, bf} : 2'b00), eo};
  endtask

  // entered and left at a falling edge
  task automatic step(input bit a, b, c, d);
    logic [5:0] e;
    t_a = a; t_b = b; t_c = c; t_d = d;
    @(posedge clock);
    #1;
    for (int i = 0; i < NI; i++) begin
      model_step(i, a, b, c, d, e);
      check($sformatf("out[%0d]@%0d", i, t + 1),
            {o_busy[i], o_pass[i], o_fail[i], o_cause[i], o_ovl[i]}, e);
`ifdef UNTIL_MON_STATS_EN
      check($sformatf("cnt[%0d]@%0d", i, t + 1), {o_pcnt[i], o_fcnt[i]}, {m_pc[i][7:0], m_fc[i][7:0]});
`endif
      if (o_pass[i] === 1'b1 && ev_pass[i] < 0) ev_pass[i] = t + 1;
      if (o_fail[i] === 1'b1 && ev_fail[i] < 0) begin
        ev_fail[i]  = t + 1;
        ev_cause[i] = o_cause[i];
      end
      if (o_ovl[i] === 1'b1 && ev_ovl[i] < 0) ev_ovl[i] = t + 1;
    end
    t++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    t_a = 0; t_b = 0; t_c = 0; t_d = 0;
    resetn = 1'b0;
    #2;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_out[%0d]", i), {o_busy[i], o_pass[i], o_fail[i], o_cause[i], o_ovl[i]}, 0);
`ifdef UNTIL_MON_STATS_EN
      check($sformatf("rst_cnt[%0d]", i), {o_pcnt[i], o_fcnt[i]}, 0);
`endif
    end
    model_reset();
    ev_clear();
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    t = 0;
  endtask

  task automatic run_scn(input logic [31:0] am, bm, cm, dm, input int ncyc);
    do_reset();
    for (int cy = 0; cy < ncyc; cy++) step(am[cy], bm[cy], cm[cy], dm[cy]);
  endtask

  initial begin
    model_reset();
    ev_clear();
    t = 0;
    @(negedge clock);

    // A rise @1, B 2-5, C 4-7, D @6
    run_scn(32'h2, 32'h3C, 32'hF0, 32'h40, 14);
    check("s1_pass0", ev_pass[0], 8);
    check("s1_fail0", ev_fail[0], -1);
    check("s1_fail1", ev_fail[1], 7);
    check("s1_cause1", ev_cause[1], 2'b01);
    check("s1_pass1", ev_pass[1], -1);
    check("s1_fail2", ev_fail[2], 4);
    check("s1_cause2", ev_cause[2], 2'b10);
    check("s1_fail3", ev_fail[3], 7);

    // D moved to cycle 7: B missing at 6
    run_scn(32'h2, 32'h3C, 32'hF0, 32'h80, 14);
    check("s2_fail0", ev_fail[0], 7);
    check("s2_cause0", ev_cause[0], 2'b01);
    check("s2_pass0", ev_pass[0], -1);

    // B 2-6, C 4-8, D @6
    run_scn(32'h2, 32'h7C, 32'h1F0, 32'h40, 14);
    check("s3_pass1", ev_pass[1], 9);
    check("s3_fail1", ev_fail[1], -1);
    check("s3_pass0", ev_pass[0], 8);

    // C only 4-5, second A rise @3
    run_scn(32'hA, 32'h3C, 32'h30, 32'h40, 14);
    check("s4_fail0", ev_fail[0], 7);
    check("s4_cause0", ev_cause[0], 2'b10);
    check("s4_ovl0", ev_ovl[0], 4);
    check("s4_pass0", ev_pass[0], -1);

    // D never arrives: weak semantics keeps every instance armed
    do_reset();
    step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    for (int cy = 2; cy < 40; cy++) step(0, 1, 1, 0);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("s5_busy[%0d]", i), o_busy[i], 1'b1);
      check($sformatf("s5_pulses[%0d]", i), {ev_pass[i], ev_fail[i]}, {-32'sd1, -32'sd1});
    end

    // mid-attempt reset is checked inside do_reset, then randomized traffic
    do_reset();
    for (int cy = 0; cy < 6000; cy++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) != 0,
           $urandom_range(0, 19) != 0, $urandom_range(0, 6) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
